// File: rtl/metronome_beat_sequencer.sv
// Metronome beat sequencer: turns BPM trigger pulses into bar-aware click windows,
// tracking beat position, run/stop state and the programmable beats-per-bar setting.
module metronome_beat_sequencer #(
   parameter int MAX_BEATS     = 8,
   parameter int DEFAULT_BEATS = 4,
   parameter int ACCENT_LEN    = 2_500_000,
   parameter int NORMAL_LEN    = 1_250_000,
   parameter int LEN_W         = 24
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_trigger,
   input  logic       i_resync,
   input  logic       i_run_toggle,
   input  logic       i_beats_inc,
   input  logic       i_beats_dec,
   output logic       o_running,
   output logic       o_click,
   output logic       o_accent,
   output logic       o_bar_start,
   output logic [3:0] o_beat_idx,
   output logic [3:0] o_beats_per_bar
);

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_CLICK = 2'd2
   } state_e;

   localparam logic [3:0]       MAX_BPB     = 4'(MAX_BEATS);
   localparam logic [3:0]       DEF_BPB     = 4'(DEFAULT_BEATS);
   localparam logic [LEN_W-1:0] ACCENT_LOAD = LEN_W'(ACCENT_LEN - 1);
   localparam logic [LEN_W-1:0] NORMAL_LOAD = LEN_W'(NORMAL_LEN - 1);

   state_e           state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic [3:0]       bpb_q, bpb_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             first_q, first_d;
   logic             accent_q, accent_d;
   logic             bar_start_q, bar_start_d;

   logic             beatZero;
   logic [3:0]       nextIdx;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= ST_STOP;
         idx_q       <= 4'd0;
         bpb_q       <= DEF_BPB;
         cnt_q       <= '0;
         first_q     <= 1'b1;
         accent_q    <= 1'b0;
         bar_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         bpb_q       <= bpb_d;
         cnt_q       <= cnt_d;
         first_q     <= first_d;
         accent_q    <= accent_d;
         bar_start_q <= bar_start_d;
      end
   end

   // A pending bar restart or a shrunken bar (bpb now <= idx) both land the next trigger on beat 0.
   always_comb begin
      beatZero = first_q | i_resync;
      if (beatZero || (idx_q >= bpb_q - 4'd1)) begin
         nextIdx = 4'd0;
      end else begin
         nextIdx = idx_q + 4'd1;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      bpb_d       = bpb_q;
      cnt_d       = cnt_q;
      first_d     = first_q;
      accent_d    = accent_q;
      bar_start_d = 1'b0;

      if (i_beats_inc && !i_beats_dec && (bpb_q < MAX_BPB)) begin
         bpb_d = bpb_q + 4'd1;
      end else if (i_beats_dec && !i_beats_inc && (bpb_q > 4'd1)) begin
         bpb_d = bpb_q - 4'd1;
      end

      case (state_q)
         ST_STOP: begin
            if (i_run_toggle) begin
               state_d = ST_WAIT;
               first_d = 1'b1;
            end
         end
         ST_WAIT, ST_CLICK: begin
            if (i_run_toggle) begin
               state_d  = ST_STOP;
               cnt_d    = '0;
               accent_d = 1'b0;
            end else if (i_trigger) begin
               state_d     = ST_CLICK;
               idx_d       = nextIdx;
               first_d     = 1'b0;
               accent_d    = (nextIdx == 4'd0);
               bar_start_d = (nextIdx == 4'd0);
               cnt_d       = (nextIdx == 4'd0) ? ACCENT_LOAD : NORMAL_LOAD;
            end else begin
               if (i_resync) begin
                  first_d = 1'b1;
               end
               if (state_q == ST_CLICK) begin
                  if (cnt_q == '0) begin
                     state_d  = ST_WAIT;
                     accent_d = 1'b0;
                  end else begin
                     cnt_d = cnt_q - 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = ST_STOP;
         end
      endcase
   end

   assign o_running       = (state_q != ST_STOP);
   assign o_click         = (state_q == ST_CLICK);
   assign o_accent        = accent_q;
   assign o_bar_start     = bar_start_q;
   assign o_beat_idx      = idx_q;
   assign o_beats_per_bar = bpb_q;

endmodule

// File: tb/tb_metronome_beat_sequencer.sv
// Testbench for metronome_beat_sequencer: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model of the metronome.
module tb_metronome_beat_sequencer;

   localparam int ACC = 8;
   localparam int NRM = 4;

   logic       clk;
   logic       rstN;
   logic       trig, resync, tog, inc, dec;
   logic       running, click, accent, barStart;
   logic [3:0] beatIdx, bpb;

   int checks;
   int passes;

   int mIdx, mBpb, mRemain;
   bit mRunning, mFirst, mBarStart;

   metronome_beat_sequencer #(
      .MAX_BEATS    (8),
      .DEFAULT_BEATS(4),
      .ACCENT_LEN   (ACC),
      .NORMAL_LEN   (NRM),
      .LEN_W        (24)
   ) dut (
      .i_clk          (clk),
      .i_reset_n      (rstN),
      .i_trigger      (trig),
      .i_resync       (resync),
      .i_run_toggle   (tog),
      .i_beats_inc    (inc),
      .i_beats_dec    (dec),
      .o_running      (running),
      .o_click        (click),
      .o_accent       (accent),
      .o_bar_start    (barStart),
      .o_beat_idx     (beatIdx),
      .o_beats_per_bar(bpb)
   );

   // 10-unit clock period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model of the metronome: remaining click cycles, beat position, bar restart pending
   task automatic modelReset();
      mIdx      = 0;
      mBpb      = 4;
      mRemain   = 0;
      mRunning  = 0;
      mFirst    = 1;
      mBarStart = 0;
   endtask

   task automatic modelStep();
      int oldBpb;
      if (!rstN) begin
         modelReset();
         return;
      end
      oldBpb    = mBpb;
      mBarStart = 0;
      if (mRemain > 0) mRemain--;
      if (inc && !dec && mBpb < 8) mBpb++;
      if (dec && !inc && mBpb > 1) mBpb--;
      if (tog) begin
         if (!mRunning) begin
            mRunning = 1;
            mFirst   = 1;
         end else begin
            mRunning = 0;
            mRemain  = 0;
         end
      end else if (mRunning) begin
         if (trig) begin
            if (mFirst || resync || (mIdx + 1 >= oldBpb)) mIdx = 0;
            else mIdx = mIdx + 1;
            mFirst    = 0;
            mRemain   = (mIdx == 0) ? ACC : NRM;
            mBarStart = (mIdx == 0);
         end else if (resync) begin
            mFirst = 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      modelStep();
      @(negedge clk);
      trig   = 1'b0;
      resync = 1'b0;
      tog    = 1'b0;
      inc    = 1'b0;
      dec    = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      modelReset();
      idle(3);
      rstN = 1'b1;
      tick();
      checks++; if (running !== 1'b0) $display("[TB] FAIL reset_running: got %b expected 0", running); else passes++;
      checks++; if (click !== 1'b0) $display("[TB] FAIL reset_click: got %b expected 0", click); else passes++;
      checks++; if (accent !== 1'b0) $display("[TB] FAIL reset_accent: got %b expected 0", accent); else passes++;
      checks++; if (barStart !== 1'b0) $display("[TB] FAIL reset_bar_start: got %b expected 0", barStart); else passes++;
      checks++; if (beatIdx !== 4'd0) $display("[TB] FAIL reset_idx: got %0d expected 0", beatIdx); else passes++;
      checks++; if (bpb !== 4'd4) $display("[TB] FAIL reset_bpb: got %0d expected 4", bpb); else passes++;
   endtask

   task automatic test_basic_bar();
      int expIdx[5] = '{0, 1, 2, 3, 0};
      int n;
      tog = 1'b1;
      tick();
      checks++; if (running !== 1'b1) $display("[TB] FAIL start_running: got %b expected 1", running); else passes++;
      for (int t = 0; t < 5; t++) begin
         trig = 1'b1;
         tick();
         checks++; if (beatIdx !== 4'(expIdx[t])) $display("[TB] FAIL bar_idx%0d: got %0d expected %0d", t, beatIdx, expIdx[t]); else passes++;
         checks++; if (accent !== (expIdx[t] == 0)) $display("[TB] FAIL bar_accent%0d: got %b expected %b", t, accent, expIdx[t] == 0); else passes++;
         checks++; if (barStart !== (expIdx[t] == 0)) $display("[TB] FAIL bar_start%0d: got %b expected %b", t, barStart, expIdx[t] == 0); else passes++;
         n = 0;
         for (int k = 0; k < 19; k++) begin
            if (click === 1'b1) n++;
            tick();
         end
         checks++; if (n != ((expIdx[t] == 0) ? ACC : NRM)) $display("[TB] FAIL click_len%0d: got %0d expected %0d", t, n, (expIdx[t] == 0) ? ACC : NRM); else passes++;
      end
   endtask

   task automatic test_retrigger();
      int n;
      resync = 1'b1;
      tick();
      trig = 1'b1;
      tick();
      checks++; if (accent !== 1'b1) $display("[TB] FAIL retrig_first_accent: got %b expected 1", accent); else passes++;
      tick();
      checks++; if (click !== 1'b1) $display("[TB] FAIL retrig_mid_click: got %b expected 1", click); else passes++;
      trig = 1'b1;
      tick();
      checks++; if (beatIdx !== 4'd1) $display("[TB] FAIL retrig_idx: got %0d expected 1", beatIdx); else passes++;
      checks++; if (accent !== 1'b0) $display("[TB] FAIL retrig_accent: got %b expected 0", accent); else passes++;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         if (click === 1'b1) n++;
         tick();
      end
      checks++; if (n != NRM) $display("[TB] FAIL retrig_len: got %0d expected %0d", n, NRM); else passes++;
   endtask

   task automatic test_stop_mid_click();
      trig = 1'b1;
      tick();
      checks++; if (beatIdx !== 4'd2) $display("[TB] FAIL stop_pre_idx: got %0d expected 2", beatIdx); else passes++;
      idle(2);
      tog = 1'b1;
      tick();
      checks++; if (click !== 1'b0) $display("[TB] FAIL stop_click: got %b expected 0", click); else passes++;
      checks++; if (running !== 1'b0) $display("[TB] FAIL stop_running: got %b expected 0", running); else passes++;
      for (int k = 0; k < 2; k++) begin
         trig = 1'b1;
         tick();
         checks++; if (click !== 1'b0 || beatIdx !== 4'd2) $display("[TB] FAIL stop_ignore%0d: got click=%b idx=%0d expected click=0 idx=2", k, click, beatIdx); else passes++;
      end
      tog = 1'b1;
      tick();
      trig = 1'b1;
      tick();
      checks++; if (beatIdx !== 4'd0) $display("[TB] FAIL restart_idx: got %0d expected 0", beatIdx); else passes++;
      checks++; if (accent !== 1'b1 || barStart !== 1'b1) $display("[TB] FAIL restart_accent: got accent=%b bar=%b expected 1 1", accent, barStart); else passes++;
   endtask

   task automatic test_bpb_limits();
      for (int k = 0; k < 3; k++) begin
         idle(10);
         trig = 1'b1;
         tick();
      end
      checks++; if (beatIdx !== 4'd3) $display("[TB] FAIL bpb_pre_idx: got %0d expected 3", beatIdx); else passes++;
      for (int k = 0; k < 3; k++) begin
         dec = 1'b1;
         tick();
      end
      checks++; if (bpb !== 4'd1) $display("[TB] FAIL bpb_dec: got %0d expected 1", bpb); else passes++;
      for (int k = 0; k < 2; k++) begin
         idle(3);
         trig = 1'b1;
         tick();
         checks++; if (beatIdx !== 4'd0 || accent !== 1'b1 || barStart !== 1'b1) $display("[TB] FAIL bpb1_beat%0d: got idx=%0d acc=%b bar=%b expected 0 1 1", k, beatIdx, accent, barStart); else passes++;
      end
      dec = 1'b1;
      tick();
      checks++; if (bpb !== 4'd1) $display("[TB] FAIL bpb_floor: got %0d expected 1", bpb); else passes++;
      inc = 1'b1;
      dec = 1'b1;
      tick();
      checks++; if (bpb !== 4'd1) $display("[TB] FAIL bpb_incdec: got %0d expected 1", bpb); else passes++;
      for (int k = 0; k < 9; k++) begin
         inc = 1'b1;
         tick();
      end
      checks++; if (bpb !== 4'd8) $display("[TB] FAIL bpb_ceiling: got %0d expected 8", bpb); else passes++;
   endtask

   task automatic test_resync();
      idle(10);
      for (int k = 0; k < 2; k++) begin
         trig = 1'b1;
         tick();
         idle(5);
      end
      checks++; if (beatIdx !== 4'd2) $display("[TB] FAIL resync_pre_idx: got %0d expected 2", beatIdx); else passes++;
      resync = 1'b1;
      tick();
      checks++; if (beatIdx !== 4'd2) $display("[TB] FAIL resync_hold_idx: got %0d expected 2", beatIdx); else passes++;
      trig = 1'b1;
      tick();
      checks++; if (beatIdx !== 4'd0 || accent !== 1'b1) $display("[TB] FAIL resync_beat0: got idx=%0d acc=%b expected 0 1", beatIdx, accent); else passes++;
      idle(9);
      trig = 1'b1;
      tick();
      idle(5);
      trig   = 1'b1;
      resync = 1'b1;
      tick();
      checks++; if (beatIdx !== 4'd0 || barStart !== 1'b1) $display("[TB] FAIL resync_same_clk: got idx=%0d bar=%b expected 0 1", beatIdx, barStart); else passes++;
   endtask

   task automatic test_async_reset();
      idle(10);
      trig = 1'b1;
      tick();
      idle(2);
      #2;
      rstN = 1'b0;
      #1;
      checks++; if (running !== 1'b0 || click !== 1'b0 || accent !== 1'b0 || barStart !== 1'b0) $display("[TB] FAIL areset_flags: got run=%b clk=%b acc=%b bar=%b expected 0 0 0 0", running, click, accent, barStart); else passes++;
      checks++; if (beatIdx !== 4'd0 || bpb !== 4'd4) $display("[TB] FAIL areset_regs: got idx=%0d bpb=%0d expected 0 4", beatIdx, bpb); else passes++;
      modelReset();
      idle(2);
      rstN = 1'b1;
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         trig   = ($urandom_range(0, 5) == 0);
         resync = ($urandom_range(0, 19) == 0);
         tog    = ($urandom_range(0, 39) == 0) || (c == 0);
         inc    = ($urandom_range(0, 24) == 0);
         dec    = ($urandom_range(0, 24) == 0);
         tick();
         checks++; if (running !== mRunning) $display("[TB] FAIL rnd_running@%0d: got %b expected %b", c, running, mRunning); else passes++;
         checks++; if (click !== (mRemain > 0)) $display("[TB] FAIL rnd_click@%0d: got %b expected %b", c, click, mRemain > 0); else passes++;
         checks++; if (accent !== (mRemain > 0 && mIdx == 0)) $display("[TB] FAIL rnd_accent@%0d: got %b expected %b", c, accent, mRemain > 0 && mIdx == 0); else passes++;
         checks++; if (barStart !== mBarStart) $display("[TB] FAIL rnd_bar_start@%0d: got %b expected %b", c, barStart, mBarStart); else passes++;
         checks++; if (beatIdx !== 4'(mIdx)) $display("[TB] FAIL rnd_idx@%0d: got %0d expected %0d", c, beatIdx, mIdx); else passes++;
         checks++; if (bpb !== 4'(mBpb)) $display("[TB] FAIL rnd_bpb@%0d: got %0d expected %0d", c, bpb, mBpb); else passes++;
      end
   endtask

   initial begin
      checks = 0;
      passes = 0;
      rstN   = 1'b0;
      trig   = 1'b0;
      resync = 1'b0;
      tog    = 1'b0;
      inc    = 1'b0;
      dec    = 1'b0;
      modelReset();
      @(negedge clk);
      test_reset();
      test_basic_bar();
      test_retrigger();
      test_stop_mid_click();
      test_bpb_limits();
      test_resync();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
